// File: rtl/cpu_pkg.sv
// Shared op encodings, FSM states and small helpers for the next-PC unit.
package cpu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SEQ  = 3'b000,
    OP_J    = 3'b001,
    OP_JAL  = 3'b010,
    OP_JR   = 3'b011,
    OP_BEQ  = 3'b100,
    OP_BNE  = 3'b101,
    OP_JALR = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that write a return address.
  function automatic logic is_link_op(input op_e op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC resolution: sequential, jump, register and branch targets.
module npc_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned TGT_W   = 26,
  parameter int unsigned OFF_W   = 16,
  parameter bit          WORD_PC = 1'b1
) (
  input  op_e              op_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [TGT_W-1:0] tgt_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [PC_W-1:0]  rs_i,
  input  logic [PC_W-1:0]  rt_i,
  output logic [PC_W-1:0]  npc_c,
  output logic [PC_W-1:0]  link_c,
  output logic             link_we_c,
  output logic             taken_c,
  output logic             err_c
);

  localparam logic [PC_W-1:0] INC = WORD_PC ? PC_W'(1) : PC_W'(4);

  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] reg_tgt;
  logic            misaligned;
  logic            br_cond;

  // Candidate targets; offsets count instructions, so byte-addressed PCs scale by 4.
  always_comb begin
    seq        = pc_i + INC;
    off_ext    = {{(PC_W-OFF_W){off_i[OFF_W-1]}}, off_i};
    br_tgt     = WORD_PC ? (seq + off_ext) : (seq + (off_ext << 2));
    jmp_tgt    = {pc_i[PC_W-1:TGT_W], tgt_i};
    reg_tgt    = WORD_PC ? (rs_i >> 2) : rs_i;
    misaligned = |rs_i[1:0];
    br_cond    = (op_i == OP_BEQ) ? (rs_i == rt_i) : (rs_i != rt_i);
  end

  // Select result per op; misaligned register jumps fall through to seq with err.
  always_comb begin
    npc_c     = seq;
    link_c    = seq;
    link_we_c = 1'b0;
    taken_c   = 1'b0;
    err_c     = 1'b0;
    case (op_i)
      OP_J, OP_JAL: begin
        npc_c     = jmp_tgt;
        taken_c   = 1'b1;
        link_we_c = is_link_op(op_i);
      end
      OP_JR, OP_JALR: begin
        if (misaligned) begin
          err_c = 1'b1;
        end else begin
          npc_c     = reg_tgt;
          taken_c   = 1'b1;
          link_we_c = is_link_op(op_i);
        end
      end
      OP_BEQ, OP_BNE: begin
        taken_c = br_cond;
        npc_c   = br_cond ? br_tgt : seq;
      end
      OP_RSVD: err_c = 1'b1;
      default: npc_c = seq;
    endcase
  end

endmodule

// File: rtl/next_pc_unit.sv
// Three-state request/response wrapper around npc_calc with captured operands.
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned TGT_W   = 26,
  parameter int unsigned OFF_W   = 16,
  parameter bit          WORD_PC = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [PC_W-1:0]  pc,
  input  logic [TGT_W-1:0] imm_target,
  input  logic [OFF_W-1:0] br_off,
  input  logic [PC_W-1:0]  rs_val,
  input  logic [PC_W-1:0]  rt_val,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  link_addr,
  output logic             link_we,
  output logic             taken,
  output logic             err,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic             capture;
  op_e              op_q;
  logic [PC_W-1:0]  pc_q, rs_q, rt_q;
  logic [TGT_W-1:0] tgt_q;
  logic [OFF_W-1:0] off_q;

  logic [PC_W-1:0]  npc_c, link_c;
  logic             link_we_c, taken_c, err_c;

  npc_calc #(
    .PC_W   (PC_W),
    .TGT_W  (TGT_W),
    .OFF_W  (OFF_W),
    .WORD_PC(WORD_PC)
  ) u_calc (
    .op_i     (op_q),
    .pc_i     (pc_q),
    .tgt_i    (tgt_q),
    .off_i    (off_q),
    .rs_i     (rs_q),
    .rt_i     (rt_q),
    .npc_c    (npc_c),
    .link_c   (link_c),
    .link_we_c(link_we_c),
    .taken_c  (taken_c),
    .err_c    (err_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; start only matters in IDLE so requests while busy are dropped.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EVAL;
          capture = 1'b1;
        end
      end
      ST_EVAL: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture at request acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_SEQ;
      pc_q  <= '0;
      tgt_q <= '0;
      off_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
    end else if (capture) begin
      op_q  <= op_e'(op);
      pc_q  <= pc;
      tgt_q <= imm_target;
      off_q <= br_off;
      rs_q  <= rs_val;
      rt_q  <= rt_val;
    end
  end

  // Registered outputs; results load on EVAL->DONE and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out    <= '0;
      link_addr <= '0;
      link_we   <= 1'b0;
      taken     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
      link_we <= (state_d == ST_DONE) && link_we_c;
      if (state_q == ST_EVAL) begin
        pc_out <= npc_c;
        taken  <= taken_c;
        err    <= err_c;
        if (link_we_c) link_addr <= link_c;
      end
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench: word-PC and byte-PC instances against a behavioural model.
module tb_next_pc_unit;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] link;
    logic        lwe;
    logic        taken;
    logic        err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] pc = '0;
  logic [25:0] imm_target = '0;
  logic [15:0] br_off = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;

  logic [31:0] pc_out, link_addr, pc_out_b, link_addr_b;
  logic        link_we, taken, err, busy, done;
  logic        link_we_b, taken_b, err_b, busy_b, done_b;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  next_pc_unit #(.WORD_PC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .pc(pc),
    .imm_target(imm_target), .br_off(br_off), .rs_val(rs_val), .rt_val(rt_val),
    .pc_out(pc_out), .link_addr(link_addr), .link_we(link_we), .taken(taken),
    .err(err), .busy(busy), .done(done)
  );

  next_pc_unit #(.WORD_PC(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .pc(pc),
    .imm_target(imm_target), .br_off(br_off), .rs_val(rs_val), .rt_val(rt_val),
    .pc_out(pc_out_b), .link_addr(link_addr_b), .link_we(link_we_b), .taken(taken_b),
    .err(err_b), .busy(busy_b), .done(done_b)
  );

  // Reference: next PC from the architectural rules using plain arithmetic.
  function automatic res_t model(input bit word, input logic [2:0] o, input logic [31:0] p,
                                 input logic [25:0] t, input logic [15:0] off,
                                 input logic [31:0] rs, input logic [31:0] rt);
    res_t r;
    int   scale;
    int   soff;
    logic [31:0] seq;
    scale = word ? 1 : 4;
    seq   = p + 32'(scale);
    soff  = int'($signed(off));
    r = '{npc: seq, link: seq, lwe: 1'b0, taken: 1'b0, err: 1'b0};
    case (o)
      3'd1, 3'd2: begin
        r.npc = (p & 32'hFC00_0000) | {6'd0, t};
        r.taken = 1'b1;
        r.lwe = (o == 3'd2);
      end
      3'd3, 3'd6: begin
        if (rs % 4 != 0) r.err = 1'b1;
        else begin
          r.npc = word ? rs / 4 : rs;
          r.taken = 1'b1;
          r.lwe = (o == 3'd6);
        end
      end
      3'd4, 3'd5: begin
        r.taken = (o == 3'd4) ? (rs == rt) : (rs != rt);
        if (r.taken) r.npc = seq + 32'(soff * scale);
      end
      3'd7: r.err = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  // Drive one request, scramble inputs after acceptance, wait for done (bounded).
  task automatic issue(input logic [2:0] o, input logic [31:0] p, input logic [25:0] t,
                       input logic [15:0] off, input logic [31:0] rs, input logic [31:0] rt,
                       output int lat);
    @(negedge clk);
    op = o; pc = p; imm_target = t; br_off = off; rs_val = rs; rt_val = rt; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom); pc = $urandom; imm_target = 26'($urandom);
    br_off = 16'($urandom); rs_val = $urandom; rt_val = $urandom;
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({pc_out, link_addr, link_we, taken, err, busy, done} !== '0)
      $display("FAIL reset_word got %h %h %b%b%b%b%b exp all zero",
               pc_out, link_addr, link_we, taken, err, busy, done);
    else n_pass++;
    n_checks++;
    if ({pc_out_b, link_addr_b, link_we_b, taken_b, err_b, busy_b, done_b} !== '0)
      $display("FAIL reset_byte got %h %h %b%b%b%b%b exp all zero",
               pc_out_b, link_addr_b, link_we_b, taken_b, err_b, busy_b, done_b);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_jump();
    int lat;
    issue(3'd1, 32'h0400_0010, 26'h000_0123, 16'h0, 32'h0, 32'h0, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL j_latency got %0d exp 2", lat); else n_pass++;
    n_checks++;
    if (pc_out !== 32'h0400_0123) $display("FAIL j_pc got %h exp 04000123", pc_out); else n_pass++;
    n_checks++;
    if ({taken, link_we, err, busy} !== 4'b1001)
      $display("FAIL j_flags got %b exp 1001", {taken, link_we, err, busy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, busy, pc_out} !== {2'b00, 32'h0400_0123})
      $display("FAIL j_after got %b%b %h exp 00 04000123", done, busy, pc_out);
    else n_pass++;
  endtask

  task automatic test_jalr();
    int lat;
    issue(3'd6, 32'h20, 26'h0, 16'h0, 32'h40, 32'h0, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL jalr_latency got %0d exp 2", lat); else n_pass++;
    n_checks++;
    if ({pc_out, link_addr} !== {32'h10, 32'h21})
      $display("FAIL jalr_addr got %h %h exp 00000010 00000021", pc_out, link_addr);
    else n_pass++;
    n_checks++;
    if ({link_we, taken, err} !== 3'b110)
      $display("FAIL jalr_flags got %b exp 110", {link_we, taken, err});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (link_we !== 1'b0) $display("FAIL jalr_we_pulse got %b exp 0", link_we); else n_pass++;
    issue(3'd6, 32'h20, 26'h0, 16'h0, 32'h42, 32'h0, lat);
    n_checks++;
    if ({pc_out, link_we, taken, err} !== {32'h21, 3'b001})
      $display("FAIL jalr_misaligned got %h %b exp 00000021 001", pc_out, {link_we, taken, err});
    else n_pass++;
  endtask

  task automatic test_branch();
    int lat;
    issue(3'd4, 32'h100, 26'h0, 16'hFFFE, 32'd5, 32'd5, lat);
    n_checks++;
    if ({pc_out, taken, err} !== {32'hFF, 2'b10})
      $display("FAIL beq_taken got %h %b exp 000000ff 10", pc_out, {taken, err});
    else n_pass++;
    n_checks++;
    if (pc_out_b !== 32'hFC) $display("FAIL beq_byte got %h exp 000000fc", pc_out_b); else n_pass++;
    issue(3'd5, 32'h100, 26'h0, 16'hFFFE, 32'd5, 32'd5, lat);
    n_checks++;
    if ({pc_out, taken, err} !== {32'h101, 2'b00})
      $display("FAIL bne_not_taken got %h %b exp 00000101 00", pc_out, {taken, err});
    else n_pass++;
  endtask

  task automatic test_seq();
    int lat;
    issue(3'd0, 32'hFFFF_FFFF, 26'h0, 16'h0, 32'h0, 32'h0, lat);
    n_checks++;
    if ({pc_out, taken, err} !== {32'h0, 2'b00})
      $display("FAIL seq_wrap got %h %b exp 00000000 00", pc_out, {taken, err});
    else n_pass++;
    issue(3'd7, 32'h1234, 26'h0, 16'h0, 32'h0, 32'h0, lat);
    n_checks++;
    if ({pc_out, taken, err, link_we} !== {32'h1235, 3'b010})
      $display("FAIL rsvd got %h %b exp 00001235 010", pc_out, {taken, err, link_we});
    else n_pass++;
    issue(3'd0, 32'h100, 26'h0, 16'h0, 32'h0, 32'h0, lat);
    n_checks++;
    if ({pc_out_b, pc_out} !== {32'h104, 32'h101})
      $display("FAIL seq_byte got %h %h exp 00000104 00000101", pc_out_b, pc_out);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    res_t ew, eb;
    logic [2:0] o;
    logic [31:0] p, rs, rt;
    logic [25:0] t;
    logic [15:0] off;
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 7));
      p = $urandom; t = 26'($urandom); off = 16'($urandom); rs = $urandom;
      if ($urandom_range(0, 1) == 1) rs[1:0] = 2'b00;
      rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      ew = model(1'b1, o, p, t, off, rs, rt);
      eb = model(1'b0, o, p, t, off, rs, rt);
      issue(o, p, t, off, rs, rt, lat);
      n_checks++;
      if (lat !== 2) $display("FAIL rnd%0d_latency got %0d exp 2", k, lat); else n_pass++;
      n_checks++;
      if ({pc_out, taken, err, link_we} !== {ew.npc, ew.taken, ew.err, ew.lwe})
        $display("FAIL rnd%0d_word op=%0d got %h %b exp %h %b", k, o, pc_out,
                 {taken, err, link_we}, ew.npc, {ew.taken, ew.err, ew.lwe});
      else n_pass++;
      n_checks++;
      if ({pc_out_b, taken_b, err_b, link_we_b} !== {eb.npc, eb.taken, eb.err, eb.lwe})
        $display("FAIL rnd%0d_byte op=%0d got %h %b exp %h %b", k, o, pc_out_b,
                 {taken_b, err_b, link_we_b}, eb.npc, {eb.taken, eb.err, eb.lwe});
      else n_pass++;
      if (ew.lwe) begin
        n_checks++;
        if ({link_addr, link_addr_b} !== {ew.link, eb.link})
          $display("FAIL rnd%0d_link got %h %h exp %h %h", k, link_addr, link_addr_b, ew.link, eb.link);
        else n_pass++;
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cnt;
    @(negedge clk);
    op = 3'd1; pc = 32'h0800_0000; imm_target = 26'h55; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    op = 3'd0; pc = 32'h300; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({done, pc_out} !== {1'b1, 32'h0800_0055})
      $display("FAIL busy_first got %b %h exp 1 08000055", done, pc_out);
    else n_pass++;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    n_checks++;
    if (cnt !== 0) $display("FAIL busy_ignored got %0d extra done exp 0", cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cnt;
    @(negedge clk);
    op = 3'd0; pc = 32'h10; start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      if (i == 8) #1 start = 1'b0;
      @(negedge clk);
      if (done) cnt++;
    end
    n_checks++;
    if (cnt !== 3) $display("FAIL b2b_pulses got %0d exp 3", cnt); else n_pass++;
    n_checks++;
    if (pc_out !== 32'h11) $display("FAIL b2b_pc got %h exp 00000011", pc_out); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int cnt, lat;
    @(negedge clk);
    op = 3'd2; pc = 32'h0C00_0000; imm_target = 26'h77; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pc_out, link_addr, link_we, taken, err, busy, done} !== '0)
      $display("FAIL abort_clear got %h %h %b%b%b%b%b exp all zero",
               pc_out, link_addr, link_we, taken, err, busy, done);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    n_checks++;
    if (cnt !== 0) $display("FAIL abort_no_done got %0d active cycles exp 0", cnt); else n_pass++;
    issue(3'd2, 32'h0C00_0000, 26'h77, 16'h0, 32'h0, 32'h0, lat);
    n_checks++;
    if ({lat == 2, pc_out, link_addr, link_we} !== {1'b1, 32'h0C00_0077, 32'h0C00_0001, 1'b1})
      $display("FAIL abort_recover got lat=%0d %h %h %b exp lat=2 0c000077 0c000001 1",
               lat, pc_out, link_addr, link_we);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_jump();
    test_jalr();
    test_branch();
    test_seq();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
